// File: rtl/frame_mux_tx.sv
// Frontend event framer: packs command responses, periodic timetags and singles
// into LENGTH-bit frames for the serializer. FRAME_MUX_TT_DROP_CNT_EN enables the tt_drops counter.
module frame_mux_tx #(
    parameter int LENGTH          = 128,
    parameter int CMD_LEN         = 32,
    parameter int TT_PERIOD       = 100000,
    parameter int SGL_FLAG_OFFSET = 122,
    parameter int CMD_FLAG_OFFSET = 115
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] sgl_data,
    input  logic              sgl_valid,
    output logic              sgl_ready,
    input  logic [CMD_LEN-1:0] cmd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [LENGTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       tt_drops
);

    localparam int DIV_W = $clog2(TT_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TT_PERIOD - 1);
    localparam logic [LENGTH-1:0] SGL_FLAG = LENGTH'(1) << SGL_FLAG_OFFSET;
    localparam logic [LENGTH-1:0] CMD_FLAG = LENGTH'(1) << CMD_FLAG_OFFSET;

    logic [DIV_W-1:0]  tt_div_q, tt_div_d;
    logic [47:0]       cycle_cnt_q, cycle_cnt_d;
    logic [47:0]       tt_val_q, tt_val_d;
    logic              tt_pend_q, tt_pend_d;
    logic [LENGTH-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic load_ok, cmd_take, tt_take, sgl_take, tick;

    always_comb begin
        load_ok  = ~out_valid_q | out_ready;
        cmd_take = load_ok & cmd_valid;
        tt_take  = load_ok & ~cmd_valid & tt_pend_q;
        sgl_take = load_ok & ~cmd_valid & ~tt_pend_q & sgl_valid;
        tick     = (tt_div_q == DIV_LAST);

        tt_div_d    = tick ? '0 : tt_div_q + DIV_W'(1);
        cycle_cnt_d = cycle_cnt_q + 48'd1;

        // A tick coinciding with consumption refills the slot; otherwise the newest tick is dropped.
        tt_val_d  = tt_val_q;
        tt_pend_d = tt_pend_q;
        if (tick && (~tt_pend_q || tt_take)) begin
            tt_val_d  = cycle_cnt_q;
            tt_pend_d = 1'b1;
        end else if (tt_take) begin
            tt_pend_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (cmd_take) begin
            out_valid_d = 1'b1;
            out_data_d  = {{(LENGTH-CMD_LEN){1'b0}}, cmd_data} | CMD_FLAG;
        end else if (tt_take) begin
            out_valid_d = 1'b1;
            out_data_d  = {{(LENGTH-48){1'b0}}, tt_val_q};
        end else if (sgl_take) begin
            out_valid_d = 1'b1;
            out_data_d  = sgl_data | SGL_FLAG;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tt_div_q    <= '0;
            cycle_cnt_q <= '0;
            tt_val_q    <= '0;
            tt_pend_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            tt_div_q    <= tt_div_d;
            cycle_cnt_q <= cycle_cnt_d;
            tt_val_q    <= tt_val_d;
            tt_pend_q   <= tt_pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FRAME_MUX_TT_DROP_CNT_EN
    logic [15:0] tt_drops_q, tt_drops_d;

    always_comb begin
        tt_drops_d = tt_drops_q;
        if (tick && tt_pend_q && ~tt_take && (tt_drops_q != 16'hFFFF))
            tt_drops_d = tt_drops_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) tt_drops_q <= '0;
        else     tt_drops_q <= tt_drops_d;
    end

    assign tt_drops = tt_drops_q;
`else
    assign tt_drops = '0;
`endif

    assign cmd_ready = load_ok;
    assign sgl_ready = load_ok & ~cmd_valid & ~tt_pend_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
